// File: rtl/display_scan_scheduler.sv
// Time-multiplexed 7-segment scan controller: per digit, one dead-time guard tick,
// then a PWM lit window and a dark remainder, all advanced by the refresh strobe.
module display_scan_scheduler #(
  parameter int N_DIGITS = 4,
  parameter int DUTY_W   = 3
) (
  input  logic                        Clk_signal,
  input  logic                        Reset_n,
  input  logic                        enable,
  input  logic                        refresh_tick,
  input  logic [N_DIGITS-1:0]         digit_mask,
  input  logic [DUTY_W-1:0]           brightness,
  output logic [N_DIGITS-1:0]         an_n,
  output logic [$clog2(N_DIGITS)-1:0] digit_sel,
  output logic                        frame_start,
  output logic                        busy
);

  localparam int SEL_W = $clog2(N_DIGITS);
  localparam logic [DUTY_W-1:0] CNT_MAX = {DUTY_W{1'b1}};

  typedef enum logic [1:0] {IDLE, GUARD, LIT, DARK} state_t;

  state_t              state_reg, state_next;
  logic [DUTY_W-1:0]   slot_cnt_reg, slot_cnt_next;
  logic [SEL_W-1:0]    digit_sel_reg, digit_sel_next;
  logic [N_DIGITS-1:0] mask_lat_reg, mask_lat_next;
  logic [DUTY_W-1:0]   br_lat_reg, br_lat_next;
  logic                frame_start_reg, frame_start_next;

  logic [SEL_W-1:0]    low_idx;
  logic [SEL_W-1:0]    next_idx;
  logic                next_found;
  logic                start_ok;
  logic                slot_end;
  logic [DUTY_W-1:0]   cnt_inc;

  // Lowest enabled digit of the live mask (used whenever a new frame begins).
  always_comb begin
    low_idx = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if (digit_mask[i]) low_idx = SEL_W'(i);
    end
  end

  // Next enabled digit of the latched mask strictly above the current one.
  always_comb begin
    next_idx   = '0;
    next_found = 1'b0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if (mask_lat_reg[i] && (i > int'(digit_sel_reg))) begin
        next_idx   = SEL_W'(i);
        next_found = 1'b1;
      end
    end
  end

  assign start_ok = enable && (|digit_mask);
  assign cnt_inc  = slot_cnt_reg + 1'b1;

  always_comb begin
    state_next       = state_reg;
    slot_cnt_next    = slot_cnt_reg;
    digit_sel_next   = digit_sel_reg;
    mask_lat_next    = mask_lat_reg;
    br_lat_next      = br_lat_reg;
    frame_start_next = 1'b0;
    slot_end         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_ok && refresh_tick) begin
          mask_lat_next    = digit_mask;
          br_lat_next      = brightness;
          digit_sel_next   = low_idx;
          slot_cnt_next    = '0;
          state_next       = GUARD;
          frame_start_next = 1'b1;
        end
      end
      GUARD: begin
        if (refresh_tick) begin
          slot_cnt_next = {{(DUTY_W-1){1'b0}}, 1'b1};
          state_next    = (br_lat_reg != '0) ? LIT : DARK;
        end
      end
      LIT: begin
        if (refresh_tick) begin
          if (slot_cnt_reg == CNT_MAX) begin
            slot_end = 1'b1;
          end else begin
            slot_cnt_next = cnt_inc;
            if (cnt_inc > br_lat_reg) state_next = DARK;
          end
        end
      end
      DARK: begin
        if (refresh_tick) begin
          if (slot_cnt_reg == CNT_MAX) slot_end = 1'b1;
          else                         slot_cnt_next = cnt_inc;
        end
      end
      default: state_next = IDLE;
    endcase

    if (slot_end) begin
      slot_cnt_next = '0;
      if (next_found) begin
        digit_sel_next = next_idx;
        state_next     = GUARD;
      end else begin
        // Frame boundary: mid-frame input changes take effect only here.
        mask_lat_next = digit_mask;
        br_lat_next   = brightness;
        if (start_ok) begin
          digit_sel_next   = low_idx;
          state_next       = GUARD;
          frame_start_next = 1'b1;
        end else begin
          digit_sel_next = '0;
          state_next     = IDLE;
        end
      end
    end

    // Disable wins over any simultaneous tick.
    if ((state_reg != IDLE) && !enable) begin
      state_next       = IDLE;
      slot_cnt_next    = '0;
      digit_sel_next   = '0;
      frame_start_next = 1'b0;
    end
  end

  always_ff @(posedge Clk_signal or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg       <= IDLE;
      slot_cnt_reg    <= '0;
      digit_sel_reg   <= '0;
      mask_lat_reg    <= '0;
      br_lat_reg      <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      slot_cnt_reg    <= slot_cnt_next;
      digit_sel_reg   <= digit_sel_next;
      mask_lat_reg    <= mask_lat_next;
      br_lat_reg      <= br_lat_next;
      frame_start_reg <= frame_start_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_anode
      assign an_n[gi] = !((state_reg == LIT) && (digit_sel_reg == SEL_W'(gi)));
    end
  endgenerate

  assign digit_sel   = digit_sel_reg;
  assign frame_start = frame_start_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Scoreboard bench for display_scan_scheduler: stimulus queues expected outputs per
// tick, a monitor pops and compares one cycle edge later.
module tb_display_scan_scheduler;

  logic       Clk_signal = 1'b0;
  logic       Reset_n    = 1'b1;
  logic       enable     = 1'b0;
  logic       refresh_tick = 1'b0;
  logic [3:0] digit_mask = 4'b0000;
  logic [2:0] brightness = 3'd0;
  logic [3:0] an_n;
  logic [1:0] digit_sel;
  logic       frame_start;
  logic       busy;

  logic       chk = 1'b0;
  int         total = 0;
  int         bad   = 0;

  typedef struct {
    logic [3:0] an;
    logic [1:0] sel;
    logic       busy;
    logic       fs;
    string      name;
  } exp_t;

  exp_t sb[$];

  display_scan_scheduler #(.N_DIGITS(4), .DUTY_W(3)) dut (
    .Clk_signal  (Clk_signal),
    .Reset_n     (Reset_n),
    .enable      (enable),
    .refresh_tick(refresh_tick),
    .digit_mask  (digit_mask),
    .brightness  (brightness),
    .an_n        (an_n),
    .digit_sel   (digit_sel),
    .frame_start (frame_start),
    .busy        (busy)
  );

  always #5 Clk_signal = ~Clk_signal;

  task automatic compare(input exp_t e);
    total++;
    if ({an_n, digit_sel, busy, frame_start} !== {e.an, e.sel, e.busy, e.fs}) begin
      bad++;
      $display("FAIL %s: got an_n=%b digit_sel=%0d busy=%b frame_start=%b, want an_n=%b digit_sel=%0d busy=%b frame_start=%b",
               e.name, an_n, digit_sel, busy, frame_start, e.an, e.sel, e.busy, e.fs);
    end else begin
      $display("pass %s: an_n=%b digit_sel=%0d busy=%b frame_start=%b",
               e.name, an_n, digit_sel, busy, frame_start);
    end
  endtask

  // Monitor: after every edge the stimulus flagged, pop one expectation and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk_signal);
      if (chk) begin
        #1;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty: got a check request, want a queued expectation");
        end else begin
          e = sb.pop_front();
          compare(e);
          if (e.fs) begin
            @(posedge Clk_signal);
            #1;
            total++;
            if (frame_start !== 1'b0) begin
              bad++;
              $display("FAIL %s_fs_width: got frame_start=%b, want 0", e.name, frame_start);
            end
          end
        end
      end
    end
  end

  task automatic push(input logic [3:0] an, input logic [1:0] sel, input logic b,
                      input logic fs, input string nm);
    exp_t e;
    e.an = an; e.sel = sel; e.busy = b; e.fs = fs; e.name = nm;
    sb.push_back(e);
  endtask

  // One refresh tick every 4 clocks; expectation describes the state after the tick.
  task automatic tick(input logic [3:0] an, input logic [1:0] sel, input logic b,
                      input logic fs, input string nm);
    push(an, sel, b, fs, nm);
    @(negedge Clk_signal);
    refresh_tick = 1'b1;
    chk = 1'b1;
    @(negedge Clk_signal);
    refresh_tick = 1'b0;
    chk = 1'b0;
    repeat (2) @(negedge Clk_signal);
  endtask

  // Eight ticks of one digit slot: guard, br lit ticks, then dark.
  task automatic slot(input int d, input int br, input logic first, input string nm);
    logic [3:0] lit_pat;
    lit_pat = ~(4'b0001 << d);
    for (int t = 0; t < 8; t++) begin
      tick(((t >= 1) && (t <= br)) ? lit_pat : 4'b1111, 2'(d), 1'b1,
           (t == 0) ? first : 1'b0, $sformatf("%s_d%0d_t%0d", nm, d, t));
    end
  endtask

  // Drop enable without a tick: must return to IDLE on the next edge.
  task automatic disable_now(input string nm);
    push(4'b1111, 2'd0, 1'b0, 1'b0, nm);
    @(negedge Clk_signal);
    enable = 1'b0;
    chk = 1'b1;
    @(negedge Clk_signal);
    chk = 1'b0;
    repeat (2) @(negedge Clk_signal);
  endtask

  task automatic direct(input string nm);
    exp_t e;
    e.an = 4'b1111; e.sel = 2'd0; e.busy = 1'b0; e.fs = 1'b0; e.name = nm;
    compare(e);
  endtask

  initial begin
    #2 Reset_n = 1'b0;
    #1 direct("reset_async");
    repeat (2) @(negedge Clk_signal);
    direct("reset_held");
    Reset_n = 1'b1;

    // Full mask, brightness 3: digits 0,1,2,3 then frame wraps to 0.
    enable = 1'b1; digit_mask = 4'b1111; brightness = 3'd3;
    slot(0, 3, 1'b1, "full");
    slot(1, 3, 1'b0, "full");
    slot(2, 3, 1'b0, "full");
    slot(3, 3, 1'b0, "full");
    slot(0, 3, 1'b1, "full_wrap");
    disable_now("full_disable");

    // Sparse mask; mask change during digit 0 only takes effect next frame.
    enable = 1'b1; digit_mask = 4'b0101; brightness = 3'd2;
    slot(0, 2, 1'b1, "sparse");
    digit_mask = 4'b1000;
    slot(2, 2, 1'b0, "sparse");
    slot(3, 2, 1'b1, "sparse_new");
    slot(3, 2, 1'b1, "sparse_new");
    disable_now("sparse_disable");

    // Brightness bounds.
    enable = 1'b1; digit_mask = 4'b1111; brightness = 3'd0;
    slot(0, 0, 1'b1, "br0");
    slot(1, 0, 1'b0, "br0");
    disable_now("br0_disable");
    enable = 1'b1; digit_mask = 4'b0010; brightness = 3'd7;
    slot(1, 7, 1'b1, "br7");
    slot(1, 7, 1'b1, "br7");

    // Disable coinciding with a tick during LIT.
    tick(4'b1111, 2'd1, 1'b1, 1'b1, "dis_guard");
    tick(4'b1101, 2'd1, 1'b1, 1'b0, "dis_lit");
    push(4'b1111, 2'd0, 1'b0, 1'b0, "dis_with_tick");
    @(negedge Clk_signal);
    enable = 1'b0; refresh_tick = 1'b1; chk = 1'b1;
    @(negedge Clk_signal);
    refresh_tick = 1'b0; chk = 1'b0;
    repeat (2) @(negedge Clk_signal);

    // Empty mask keeps the scheduler idle; a non-empty mask then starts a frame.
    enable = 1'b1; digit_mask = 4'b0000;
    tick(4'b1111, 2'd0, 1'b0, 1'b0, "empty_a");
    tick(4'b1111, 2'd0, 1'b0, 1'b0, "empty_b");
    digit_mask = 4'b0010;
    tick(4'b1111, 2'd1, 1'b1, 1'b1, "empty_start");
    tick(4'b1101, 2'd1, 1'b1, 1'b0, "empty_lit");

    // Asynchronous reset between clock edges while lit.
    #2 Reset_n = 1'b0;
    #1 direct("reset_mid_lit");
    digit_mask = 4'b1111; brightness = 3'd3;
    repeat (2) @(negedge Clk_signal);
    direct("reset_mid_held");
    Reset_n = 1'b1;
    slot(0, 3, 1'b1, "restart");
    slot(1, 3, 1'b0, "restart");

    repeat (4) @(negedge Clk_signal);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    total++;
    $display("FAIL watchdog: got timeout at %0t, want completion", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_scan_scheduler.md
# display_scan_scheduler

Time-multiplexing controller for the multi-digit 7-segment display. It consumes the one-cycle refresh strobe from the free-running refresh counter and steps through the enabled digits in order. For each digit it drives a dead-time guard tick, then a PWM-controlled lit window, so segment data can settle before the anode turns on and brightness is set by duty cycle. It sits between the refresh counter and the segment/anode pins. Its digit index selects which digit's segment pattern the segment mux drives.

## Interface
- N_DIGITS, 4, number of digits scanned (2..8)
- DUTY_W, 3, width of brightness and slot tick counter; slot length = 2**DUTY_W ticks
- Clk_signal  in  1  system clock; all state changes on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- enable  in  1  scan run request
- refresh_tick  in  1  one-cycle strobe from the refresh counter; advances the scheduler
- digit_mask  in  N_DIGITS  1 = digit included in the scan
- brightness  in  DUTY_W  lit ticks per slot, 0..2**DUTY_W-1
- an_n  out  N_DIGITS  active-low anode drive, at most one bit low
- digit_sel  out  $clog2(N_DIGITS)  index of the digit currently owning the slot
- frame_start  out  1  one-cycle pulse at the start of each frame
- busy  out  1  high whenever state is not IDLE

## Operation
- **States:** IDLE, GUARD, LIT, DARK. A slot_cnt register (DUTY_W bits) counts ticks within a slot.
- **Latching:**
  - mask_lat and br_lat capture digit_mask and brightness only at a frame start.
  - Input changes mid-frame are ignored until the next frame.
- **IDLE:**
  - an_n is all ones and digit_sel is 0.
  - When enable=1, digit_mask≠0 and refresh_tick=1: latch mask_lat and br_lat, set digit_sel to the lowest set bit of digit_mask, set slot_cnt to 0, and go to GUARD as a new frame.
- **GUARD** (slot_cnt=0, all anodes off):
  - On a tick, slot_cnt becomes 1.
  - Go to LIT if br_lat≥1, else go to DARK.
- **LIT:**
  - an_n[digit_sel]=0.
  - On a tick, slot_cnt increments; leave for DARK when the new slot_cnt > br_lat.
  - If slot_cnt was 2**DUTY_W-1, the slot ends instead.
- **DARK:**
  - All anodes are off.
  - On a tick, slot_cnt increments; at slot_cnt = 2**DUTY_W-1 the tick ends the slot.
- **Slot end:**
  - Next digit = next set bit of mask_lat above digit_sel.
  - If there is none, the frame ends:
    - Re-latch the mask and brightness inputs.
    - If enable=0 or digit_mask=0, go to IDLE.
    - Otherwise start a new frame at the lowest set bit.
  - Enter GUARD with slot_cnt=0.
- **Lit ticks per slot:** exactly br_lat, i.e. ticks 1..br_lat. The guard tick is always dark. Maximum duty is (2**DUTY_W-1)/2**DUTY_W.
- **Frame length:** popcount(mask_lat)·2**DUTY_W ticks.
- **enable=0 in any non-IDLE state:** go to IDLE at the next clock edge, regardless of refresh_tick. Disable has priority over a simultaneous tick.
- **Output decode:** an_n, busy and frame_start are decoded only from registers; there is no input-to-output combinational path.

## Timing
- **Reset values:** state=IDLE, an_n=all ones, digit_sel=0, frame_start=0, busy=0, slot_cnt=0, mask_lat=0, br_lat=0.
- **Reset assertion:** forces these values immediately, without waiting for a clock edge.
- **Reset deassertion:** scan begins on the first refresh_tick that satisfies the IDLE start conditions.
- **Transitions:** every transition except disable occurs on the clock edge where refresh_tick=1. Ticks are assumed to be at least one clock apart.
- **digit_sel** changes only on entry to GUARD, so the segment mux has one full tick of dead time before the anode turns on.
- **an_n** goes low in the first cycle of LIT and high in the first cycle after LIT.
- **frame_start** is 1 for exactly one clock: the first cycle of GUARD for the first digit of each frame.
- **busy** rises in the first cycle of GUARD and falls in the first cycle of IDLE.

## Test plan
All scenarios use N_DIGITS=4 and DUTY_W=3.
1. **Full mask:** enable=1, mask=4'b1111, brightness=3, tick every 4 clocks → each slot is 1 guard, 3 lit and 4 dark ticks. Order is 0,1,2,3,0. an_n patterns are 1110/1101/1011/0111. frame_start pulses once per 32 ticks.
2. **Sparse mask:** mask=4'b0101 → only digits 0,2 are scanned and the frame is 16 ticks. Changing mask to 4'b1000 during digit 0's slot → digit 2's slot still completes, then the next frame scans digit 3 only.
3. **Brightness bounds:** brightness=0 → an_n stays 1111 while busy=1 and digit_sel still sequences. brightness=7 → 7 lit ticks, 1 dark (guard) tick per slot.
4. **Disable vs tick:** drop enable in the same cycle as a tick during LIT → next edge is IDLE with an_n=1111, busy=0, and no digit advance.
5. **Empty mask start:** enable=1, mask=0 → remains IDLE across ticks. Set mask=4'b0010 → the next tick enters GUARD with digit_sel=1 and frame_start=1.
6. **Asynchronous reset:** assert Reset_n=0 mid-LIT between clock edges → an_n=1111 and busy=0 immediately. After release, the scan restarts from digit 0 on the first tick.
